// File: rtl/serial_frame_rx_if.sv
// Signal bundle between a serial frame source and the frame receiver.
// master: drives the serial line and observes the receiver outputs.
// slave : the receiver itself.
`timescale 1ns/1ps
interface serial_frame_rx_if #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 2
);
  logic              rx;
  logic [DATA_W-1:0] data_out;
  logic [CH_W-1:0]   ch_out;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              ch_err;
  logic              busy;

  modport master (
    output rx,
    input  data_out, ch_out, valid, parity_err, frame_err, ch_err, busy
  );

  modport slave (
    input  rx,
    output data_out, ch_out, valid, parity_err, frame_err, ch_err, busy
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: recovers {channel id, payload} frames from a single
// oversampled line, checks start/parity/stop and reports one pulse per frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | half-bit wait, confirm start bit at its centre
// SHIFT     | sample id+data bits at bit centres, LSB first
// PARITY    | sample even-parity bit
// STOP      | sample stop bit, issue exactly one outcome pulse
// WAIT_IDLE | after a low stop bit, hold until the line returns high
`timescale 1ns/1ps
module serial_frame_rx #(
  parameter int DATA_W       = 8,
  parameter int CH_W         = 2,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_frame_rx_if.slave bus
);
  localparam int FRAME_W = CH_W + DATA_W;
  localparam int CYC_W   = $clog2(CLKS_PER_BIT);
  localparam int BIT_W   = $clog2(FRAME_W + 1);
  localparam logic [CYC_W-1:0] HALF_TC    = CYC_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CYC_W-1:0] FULL_TC    = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_W - 1);
  localparam logic [CH_W-1:0]  ILLEGAL_CH = '1;

  typedef enum logic [2:0] {IDLE, START, SHIFT, PARITY, STOP, WAIT_IDLE} state_t;

  state_t             r_state, w_next;
  logic               r_sync1, r_rx_s;
  logic [CYC_W-1:0]   r_cyc;
  logic [BIT_W-1:0]   r_bit;
  logic [FRAME_W-1:0] r_shift;
  logic               r_parity_ok;
  logic [DATA_W-1:0]  r_data_out;
  logic [CH_W-1:0]    r_ch_out;
  logic               r_valid, r_parity_err, r_frame_err, r_ch_err;

  logic w_tc, w_sample_bit, w_par_ok_now;
  logic w_set_valid, w_set_perr, w_set_ferr, w_set_cerr;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_rx_s  <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode, sample strobes and outcome selection.
  always_comb begin
    w_next       = r_state;
    w_tc         = 1'b0;
    w_sample_bit = 1'b0;
    w_set_valid  = 1'b0;
    w_set_perr   = 1'b0;
    w_set_ferr   = 1'b0;
    w_set_cerr   = 1'b0;
    w_par_ok_now = ~(^{r_shift, r_rx_s});
    case (r_state)
      IDLE: if (!r_rx_s) w_next = START;
      START: begin
        if (r_cyc == HALF_TC) begin
          w_tc   = 1'b1;
          w_next = r_rx_s ? IDLE : SHIFT;
        end
      end
      SHIFT: begin
        if (r_cyc == FULL_TC) begin
          w_tc         = 1'b1;
          w_sample_bit = 1'b1;
          if (r_bit == LAST_BIT) w_next = PARITY;
        end
      end
      PARITY: begin
        if (r_cyc == FULL_TC) begin
          w_tc   = 1'b1;
          w_next = STOP;
        end
      end
      STOP: begin
        if (r_cyc == FULL_TC) begin
          w_tc = 1'b1;
          if (!r_rx_s) begin
            w_set_ferr = 1'b1;
            w_next     = WAIT_IDLE;
          end else begin
            w_next = IDLE;
            if (!r_parity_ok)                          w_set_perr  = 1'b1;
            else if (r_shift[CH_W-1:0] == ILLEGAL_CH) w_set_cerr  = 1'b1;
            else                                       w_set_valid = 1'b1;
          end
        end
      end
      WAIT_IDLE: if (r_rx_s) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bit timing counters and frame shift register; counters clear on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_parity_ok <= 1'b0;
    end else begin
      if (w_next != r_state || w_tc)               r_cyc <= '0;
      else if (r_state != IDLE && r_state != WAIT_IDLE) r_cyc <= r_cyc + 1'b1;

      if (w_next != r_state) r_bit <= '0;
      else if (w_sample_bit) r_bit <= r_bit + 1'b1;

      if (w_sample_bit) r_shift <= {r_rx_s, r_shift[FRAME_W-1:1]};
      if (r_state == PARITY && w_tc) r_parity_ok <= w_par_ok_now;
    end
  end

  // Registered outcome pulses; payload only updates on a good frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= '0;
      r_ch_out     <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_ch_err     <= 1'b0;
    end else begin
      r_valid      <= w_set_valid;
      r_parity_err <= w_set_perr;
      r_frame_err  <= w_set_ferr;
      r_ch_err     <= w_set_cerr;
      if (w_set_valid) begin
        r_data_out <= r_shift[FRAME_W-1:CH_W];
        r_ch_out   <= r_shift[CH_W-1:0];
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.ch_out     = r_ch_out;
  assign bus.valid      = r_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.ch_err     = r_ch_err;
  assign bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: a behavioural transmitter drives the
// line, a negedge monitor tallies outcome pulses, each task checks its scenario.
`timescale 1ns/1ps
module tb_serial_frame_rx;
  localparam int DATA_W = 8;
  localparam int CH_W   = 2;
  localparam int CPB    = 16;
  localparam int LAT    = 203;  // drive edge to pulse: 2 sync edges + 8 + 12*16 + 1

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_cerr = 0, n_multi = 0;
  int last_valid_cyc = 0, last_pulse_cyc = 0;
  logic [9:0] vlog[$];

  serial_frame_rx_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus();

  serial_frame_rx #(.DATA_W(DATA_W), .CH_W(CH_W), .CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor.
  always @(negedge clk) begin
    int np;
    np = int'(bus.valid === 1'b1) + int'(bus.parity_err === 1'b1) +
         int'(bus.frame_err === 1'b1) + int'(bus.ch_err === 1'b1);
    if (np > 1) n_multi++;
    if (np > 0) last_pulse_cyc = cyc;
    if (bus.valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
      vlog.push_back({bus.ch_out, bus.data_out});
    end
    if (bus.parity_err === 1'b1) n_perr++;
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.ch_err === 1'b1) n_cerr++;
  end

  function automatic logic [12:0] mk_frame(input logic [1:0] ch, input logic [7:0] d,
                                           input logic par_flip, input logic stop_v);
    logic p;
    p = (^{d, ch}) ^ par_flip;
    return {stop_v, p, d, ch, 1'b0};
  endfunction

  // Starts and ends #1 after a rising edge; bit 0 goes on the wire first.
  task automatic tx_bits(input logic [12:0] frame);
    for (int i = 0; i < 13; i++) begin
      bus.rx = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    bus.rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({bus.data_out, bus.ch_out, bus.valid, bus.parity_err, bus.frame_err, bus.ch_err, bus.busy} !== '0)
      begin failures++; $display("FAIL reset_outputs: got %h want 0",
        {bus.data_out, bus.ch_out, bus.valid, bus.parity_err, bus.frame_err, bus.ch_err, bus.busy}); end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if ({bus.data_out, bus.ch_out, bus.valid, bus.parity_err, bus.frame_err, bus.ch_err, bus.busy} !== '0)
        bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL idle_after_reset: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_single();
    int v0, e0, c0;
    v0 = n_valid; e0 = n_perr + n_ferr + n_cerr; c0 = cyc;
    tx_bits(mk_frame(2'd1, 8'hA5, 1'b0, 1'b1));
    checks++;
    if (n_valid - v0 != 1) begin failures++; $display("FAIL single_valid_count: got %0d want 1", n_valid - v0); end
    checks++;
    if (last_valid_cyc - c0 != LAT) begin failures++; $display("FAIL single_latency: got %0d want %0d", last_valid_cyc - c0, LAT); end
    checks++;
    if (bus.data_out !== 8'hA5) begin failures++; $display("FAIL single_data: got %h want a5", bus.data_out); end
    checks++;
    if (bus.ch_out !== 2'd1) begin failures++; $display("FAIL single_ch: got %0d want 1", bus.ch_out); end
    checks++;
    if (n_perr + n_ferr + n_cerr - e0 != 0) begin failures++; $display("FAIL single_no_err: got %0d want 0", n_perr + n_ferr + n_cerr - e0); end
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (bus.data_out !== 8'hA5) begin failures++; $display("FAIL single_data_held: got %h want a5", bus.data_out); end
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin failures++; $display("FAIL single_quiet: got busy=%b valid=%b want 0 0", bus.busy, bus.valid); end
  endtask

  task automatic test_parity();
    int v0, p0, c0;
    v0 = n_valid; p0 = n_perr; c0 = cyc;
    tx_bits(mk_frame(2'd0, 8'h3C, 1'b1, 1'b1));
    checks++;
    if (n_perr - p0 != 1) begin failures++; $display("FAIL parity_err_count: got %0d want 1", n_perr - p0); end
    checks++;
    if (last_pulse_cyc - c0 != LAT) begin failures++; $display("FAIL parity_latency: got %0d want %0d", last_pulse_cyc - c0, LAT); end
    checks++;
    if (n_valid - v0 != 0) begin failures++; $display("FAIL parity_no_valid: got %0d want 0", n_valid - v0); end
    checks++;
    if (bus.data_out !== 8'hA5 || bus.ch_out !== 2'd1) begin failures++; $display("FAIL parity_data_kept: got %h/%0d want a5/1", bus.data_out, bus.ch_out); end
  endtask

  task automatic test_frame_err();
    int v0, f0, o0;
    v0 = n_valid; f0 = n_ferr; o0 = n_perr + n_cerr;
    tx_bits(mk_frame(2'd2, 8'h55, 1'b0, 1'b0));
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (n_ferr - f0 != 1) begin failures++; $display("FAIL frame_err_count: got %0d want 1", n_ferr - f0); end
    checks++;
    if (n_valid - v0 != 0 || n_perr + n_cerr - o0 != 0) begin failures++; $display("FAIL frame_err_only: got valid=%0d other=%0d want 0 0", n_valid - v0, n_perr + n_cerr - o0); end
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL frame_err_busy_low_line: got %b want 1", bus.busy); end
    bus.rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL frame_err_busy_release: got %b want 0", bus.busy); end
    checks++;
    if (bus.data_out !== 8'hA5 || n_ferr - f0 != 1) begin failures++; $display("FAIL frame_err_after: got data=%h ferr=%0d want a5 1", bus.data_out, n_ferr - f0); end
  endtask

  task automatic test_ch_err();
    int v0, c0, o0;
    v0 = n_valid; c0 = n_cerr; o0 = n_perr + n_ferr;
    tx_bits(mk_frame(2'd3, 8'h81, 1'b0, 1'b1));
    checks++;
    if (n_cerr - c0 != 1) begin failures++; $display("FAIL ch_err_count: got %0d want 1", n_cerr - c0); end
    checks++;
    if (n_valid - v0 != 0 || n_perr + n_ferr - o0 != 0) begin failures++; $display("FAIL ch_err_only: got valid=%0d other=%0d want 0 0", n_valid - v0, n_perr + n_ferr - o0); end
    checks++;
    if (bus.data_out !== 8'hA5 || bus.ch_out !== 2'd1) begin failures++; $display("FAIL ch_err_data_kept: got %h/%0d want a5/1", bus.data_out, bus.ch_out); end
  endtask

  task automatic test_glitch();
    int t0;
    t0 = n_valid + n_perr + n_ferr + n_cerr;
    bus.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen: got %b want 1", bus.busy); end
    bus.rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (n_valid + n_perr + n_ferr + n_cerr - t0 != 0) begin failures++; $display("FAIL glitch_no_pulse: got %0d want 0", n_valid + n_perr + n_ferr + n_cerr - t0); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_midframe();
    logic [12:0] f;
    int t0;
    f = mk_frame(2'd1, 8'h5A, 1'b0, 1'b1);
    t0 = n_valid + n_perr + n_ferr + n_cerr;
    for (int i = 0; i < 5; i++) begin
      bus.rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.data_out, bus.ch_out, bus.valid, bus.parity_err, bus.frame_err, bus.ch_err, bus.busy} !== '0)
      begin failures++; $display("FAIL midreset_outputs: got %h want 0",
        {bus.data_out, bus.ch_out, bus.valid, bus.parity_err, bus.frame_err, bus.ch_err, bus.busy}); end
    bus.rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (n_valid + n_perr + n_ferr + n_cerr - t0 != 0) begin failures++; $display("FAIL midreset_no_pulse: got %0d want 0", n_valid + n_perr + n_ferr + n_cerr - t0); end
    checks++;
    if (bus.busy !== 1'b0 || bus.data_out !== 8'h00) begin failures++; $display("FAIL midreset_idle: got busy=%b data=%h want 0 00", bus.busy, bus.data_out); end
  endtask

  task automatic test_back_to_back();
    int v0, e0, idx0, bad;
    int nxt[3];
    logic [9:0] ent;
    v0 = n_valid; e0 = n_perr + n_ferr + n_cerr; idx0 = vlog.size();
    for (int w = 1; w <= 30; w++)
      for (int c = 0; c < 3; c++)
        tx_bits(mk_frame(2'(c), 8'(w), 1'b0, 1'b1));
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (n_valid - v0 != 90) begin failures++; $display("FAIL b2b_valid_count: got %0d want 90", n_valid - v0); end
    checks++;
    if (n_perr + n_ferr + n_cerr - e0 != 0) begin failures++; $display("FAIL b2b_no_err: got %0d want 0", n_perr + n_ferr + n_cerr - e0); end
    nxt[0] = 1; nxt[1] = 1; nxt[2] = 1;
    bad = 0;
    for (int i = idx0; i < vlog.size(); i++) begin
      ent = vlog[i];
      if (ent[9:8] == 2'd3) bad++;
      else begin
        if (int'(ent[7:0]) != nxt[ent[9:8]]) bad++;
        nxt[ent[9:8]]++;
      end
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL b2b_order: got %0d out-of-order entries want 0", bad); end
    checks++;
    if (nxt[0] != 31 || nxt[1] != 31 || nxt[2] != 31) begin failures++; $display("FAIL b2b_per_channel: got %0d/%0d/%0d want 30/30/30", nxt[0] - 1, nxt[1] - 1, nxt[2] - 1); end
    checks++;
    if (n_multi != 0) begin failures++; $display("FAIL overlapping_pulses: got %0d want 0", n_multi); end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_single();
    test_parity();
    test_frame_err();
    test_ch_err();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
